// File: rtl/sdram_frame_bank_mgr.sv
// SDRAM frame bank manager: steers the camera writer and LCD reader between
// two (ping-pong) or three (triple-buffer) SDRAM banks. It produces bank
// selects, start/max addresses and address-reload pulses, and flags frames
// that were dropped (overwritten unread) or repeated (re-read).
module sdram_frame_bank_mgr #(
    parameter int MODE        = 1,
    parameter int BANK_BASE   = 0,
    parameter int ADDR_W      = 20,
    parameter int FRAME_SIZE  = 307200,
    parameter int LOAD_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bank_valid,
    input  logic              frame_write_done,
    input  logic              frame_read_done,
    output logic [1:0]        wr_bank,
    output logic [1:0]        rd_bank,
    output logic [ADDR_W+1:0] wr_addr,
    output logic [ADDR_W+1:0] wr_max_addr,
    output logic [ADDR_W+1:0] rd_addr,
    output logic [ADDR_W+1:0] rd_max_addr,
    output logic              wr_load,
    output logic              rd_load,
    output logic              frame_drop,
    output logic              frame_repeat
);

    localparam logic [1:0]        BANK_W0 = 2'(BANK_BASE);
    localparam logic [1:0]        BANK_R0 = 2'(BANK_BASE + 1);
    // The spare bank only exists in triple-buffer mode.
    localparam logic [1:0]        BANK_Y0 = (MODE == 1) ? 2'(BANK_BASE + 2) : 2'd0;
    localparam logic [3:0]        LOAD_W  = 4'(LOAD_CYCLES);
    localparam logic [ADDR_W-1:0] FS_LOW  = ADDR_W'(FRAME_SIZE);

    logic       wd_q, rd_q;
    logic       wd_ev, rd_ev;
    logic [1:0] rdy;
    logic       rdy_flag, wpend, rpend;
    logic [3:0] wr_cnt, rd_cnt;

    logic [1:0] n_wr_bank, n_rd_bank, n_rdy;
    logic       n_rdy_flag, n_wpend, n_rpend;
    logic       wr_start, rd_start, n_drop, n_repeat;
    logic [3:0] n_wr_cnt, n_rd_cnt;

    // A level held high counts once; write completions only count while frames are valid.
    assign wd_ev = frame_write_done & ~wd_q & bank_valid;
    assign rd_ev = frame_read_done & ~rd_q;

    // Next-state decision for bank rotation, flags and reload-pulse starts.
    always_comb begin
        n_wr_bank  = wr_bank;
        n_rd_bank  = rd_bank;
        n_rdy      = rdy;
        n_rdy_flag = rdy_flag;
        n_wpend    = wpend;
        n_rpend    = rpend;
        wr_start   = 1'b0;
        rd_start   = 1'b0;
        n_drop     = 1'b0;
        n_repeat   = 1'b0;
        if (MODE == 1) begin
            if (wd_ev && rd_ev) begin
                // Writer takes the spare, reader takes the just-finished frame.
                n_wr_bank  = rdy;
                n_rd_bank  = wr_bank;
                n_rdy      = rd_bank;
                n_rdy_flag = 1'b0;
                n_drop     = rdy_flag;
                wr_start   = 1'b1;
                rd_start   = 1'b1;
            end else if (wd_ev) begin
                n_rdy      = wr_bank;
                n_wr_bank  = rdy;
                n_rdy_flag = 1'b1;
                n_drop     = rdy_flag;
                wr_start   = 1'b1;
            end else if (rd_ev) begin
                rd_start = 1'b1;
                if (rdy_flag) begin
                    n_rd_bank  = rdy;
                    n_rdy      = rd_bank;
                    n_rdy_flag = 1'b0;
                end else begin
                    n_repeat = 1'b1;
                end
            end
        end else begin
            if ((wpend | wd_ev) & (rpend | rd_ev)) begin
                n_wr_bank = rd_bank;
                n_rd_bank = wr_bank;
                n_wpend   = 1'b0;
                n_rpend   = 1'b0;
                wr_start  = 1'b1;
                rd_start  = 1'b1;
            end else begin
                if (wd_ev) begin
                    n_wpend = 1'b1;
                    if (wpend) begin
                        wr_start = 1'b1;
                        n_drop   = 1'b1;
                    end
                end
                if (rd_ev) begin
                    n_rpend  = 1'b1;
                    rd_start = 1'b1;
                    n_repeat = 1'b1;
                end
            end
        end
        n_wr_cnt = wr_start ? LOAD_W : ((wr_cnt != 4'd0) ? wr_cnt - 4'd1 : 4'd0);
        n_rd_cnt = rd_start ? LOAD_W : ((rd_cnt != 4'd0) ? rd_cnt - 4'd1 : 4'd0);
    end

    // State and pulse registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q         <= 1'b0;
            rd_q         <= 1'b0;
            wr_bank      <= BANK_W0;
            rd_bank      <= BANK_R0;
            rdy          <= BANK_Y0;
            rdy_flag     <= 1'b0;
            wpend        <= 1'b0;
            rpend        <= 1'b0;
            wr_cnt       <= 4'd0;
            rd_cnt       <= 4'd0;
            frame_drop   <= 1'b0;
            frame_repeat <= 1'b0;
        end else begin
            wd_q         <= frame_write_done;
            rd_q         <= frame_read_done;
            wr_bank      <= n_wr_bank;
            rd_bank      <= n_rd_bank;
            rdy          <= n_rdy;
            rdy_flag     <= n_rdy_flag;
            wpend        <= n_wpend;
            rpend        <= n_rpend;
            wr_cnt       <= n_wr_cnt;
            rd_cnt       <= n_rd_cnt;
            frame_drop   <= n_drop;
            frame_repeat <= n_repeat;
        end
    end

    assign wr_load     = (wr_cnt != 4'd0);
    assign rd_load     = (rd_cnt != 4'd0);
    assign wr_addr     = {wr_bank, {ADDR_W{1'b0}}};
    assign wr_max_addr = {wr_bank, FS_LOW};
    assign rd_addr     = {rd_bank, {ADDR_W{1'b0}}};
    assign rd_max_addr = {rd_bank, FS_LOW};

endmodule
